// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory-master port among instruction fetch, data read and
//   data write. A single transaction is outstanding at a time: the winner's
//   word-aligned address (and write data) is latched in IDLE, the strobe is
//   held through WAIT until mem_ready_n is low, the granted requester gets
//   a one-cycle valid pulse, and DONE inserts one dead cycle before
//   arbitration resumes.
//
//   Optional feature macro: MEM_PORT_ARBITER_RR_EN
//     undefined : fixed priority write > data read > instruction
//     defined   : round-robin, last granted requester becomes lowest
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   ia / ia_enable               instruction fetch address / request
//   iv / iv_valid                fetched word / completion pulse
//   da_in / da_in_enable         data-read address / request
//   dv_in / dv_in_valid          read word / completion pulse
//   da_out / da_out_enable       data-write address / request
//   dv_out / dv_out_valid        write word / completion pulse
//   mem_address                  word-aligned memory address
//   mem_read_n, mem_write_n      active-low strobes
//   mem_write_data               write data to memory
//   mem_read_data, mem_ready_n   read data / active-low ready from memory
//   busy                         high whenever not in IDLE
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           ia,
    input  logic                  ia_enable,
    output logic [DATA_WIDTH-1:0] iv,
    output logic                  iv_valid,
    input  logic [31:0]           da_in,
    input  logic                  da_in_enable,
    output logic [DATA_WIDTH-1:0] dv_in,
    output logic                  dv_in_valid,
    input  logic [31:0]           da_out,
    input  logic                  da_out_enable,
    input  logic [DATA_WIDTH-1:0] dv_out,
    output logic                  dv_out_valid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read_n,
    output logic                  mem_write_n,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready_n,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {G_NONE, G_INSTR, G_READ, G_WRITE} grant_t;

    state_t state, state_nx;
    grant_t grant, grant_nx;

    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx, iv_nx, dv_in_nx;
    logic                  rd_n_nx, wr_n_nx;
    logic                  iv_valid_nx, dv_in_valid_nx, dv_out_valid_nx;

    // Requester index: 0 = instruction, 1 = data read, 2 = data write
    logic [2:0]  req;
    logic        win_found;
    logic [1:0]  win_idx;
    logic [31:0] win_addr;

    assign req = {da_out_enable, da_in_enable, ia_enable};

    // Upper/low address bits are intentionally dropped by the alignment
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ia, da_in, da_out};

`ifdef MEM_PORT_ARBITER_RR_EN
    logic [1:0] last_idx, last_nx;

    // Candidate k (1..3) in descending index order starting just below the
    // last grant, so the last granted requester is checked last.
    function automatic logic [1:0] rot(input logic [1:0] last, input int k);
        int v;
        v = (int'(last) + 3 - k) % 3;
        return v[1:0];
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            if (!win_found && req[rot(last_idx, k)]) begin
                win_found = 1'b1;
                win_idx   = rot(last_idx, k);
            end
        end
    end
`else
    always_comb begin
        win_found = |req;
        if (req[2])      win_idx = 2'd2;
        else if (req[1]) win_idx = 2'd1;
        else             win_idx = 2'd0;
    end
`endif

    always_comb begin
        case (win_idx)
            2'd2:    win_addr = da_out;
            2'd1:    win_addr = da_in;
            default: win_addr = ia;
        endcase
    end

    always_comb begin
        state_nx        = state;
        grant_nx        = grant;
        addr_nx         = mem_address;
        wdata_nx        = mem_write_data;
        rd_n_nx         = mem_read_n;
        wr_n_nx         = mem_write_n;
        iv_nx           = iv;
        dv_in_nx        = dv_in;
        iv_valid_nx     = 1'b0;
        dv_in_valid_nx  = 1'b0;
        dv_out_valid_nx = 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
        last_nx         = last_idx;
`endif
        case (state)
            S_IDLE: begin
                rd_n_nx = 1'b1;
                wr_n_nx = 1'b1;
                if (win_found) begin
                    state_nx = S_WAIT;
                    addr_nx  = {win_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef MEM_PORT_ARBITER_RR_EN
                    last_nx  = win_idx;
`endif
                    case (win_idx)
                        2'd2: begin
                            grant_nx = G_WRITE;
                            wr_n_nx  = 1'b0;
                            wdata_nx = dv_out;
                        end
                        2'd1: begin
                            grant_nx = G_READ;
                            rd_n_nx  = 1'b0;
                        end
                        default: begin
                            grant_nx = G_INSTR;
                            rd_n_nx  = 1'b0;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                if (!mem_ready_n) begin
                    state_nx = S_DONE;
                    rd_n_nx  = 1'b1;
                    wr_n_nx  = 1'b1;
                    case (grant)
                        G_INSTR: begin
                            iv_nx       = mem_read_data;
                            iv_valid_nx = 1'b1;
                        end
                        G_READ: begin
                            dv_in_nx       = mem_read_data;
                            dv_in_valid_nx = 1'b1;
                        end
                        G_WRITE: dv_out_valid_nx = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                grant_nx = G_NONE;
                rd_n_nx  = 1'b1;
                wr_n_nx  = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
                grant_nx = G_NONE;
                rd_n_nx  = 1'b1;
                wr_n_nx  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            grant          <= G_NONE;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read_n     <= 1'b1;
            mem_write_n    <= 1'b1;
            iv             <= '0;
            dv_in          <= '0;
            iv_valid       <= 1'b0;
            dv_in_valid    <= 1'b0;
            dv_out_valid   <= 1'b0;
            busy           <= 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
            // Instruction as "last granted" gives write > read > instruction
            last_idx       <= 2'd0;
`endif
        end else begin
            state          <= state_nx;
            grant          <= grant_nx;
            mem_address    <= addr_nx;
            mem_write_data <= wdata_nx;
            mem_read_n     <= rd_n_nx;
            mem_write_n    <= wr_n_nx;
            iv             <= iv_nx;
            dv_in          <= dv_in_nx;
            iv_valid       <= iv_valid_nx;
            dv_in_valid    <= dv_in_valid_nx;
            dv_out_valid   <= dv_out_valid_nx;
            busy           <= (state_nx != S_IDLE);
`ifdef MEM_PORT_ARBITER_RR_EN
            last_idx       <= last_nx;
`endif
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory-master port among the core's three requesters: instruction fetch, data read and data write.
- Sits between the core and the system interconnect, replacing three independent memory ports with one.
- Serialises requests and returns one registered completion per transaction to the requester that was granted.
- Only one transaction is outstanding at any time.

Parameters:
ADDR_WIDTH, 25, width of the byte address on the memory port
DATA_WIDTH, 32, width of instruction and data words

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
ia  in  32  instruction byte address
ia_enable  in  1  instruction fetch request (level)
iv  out  DATA_WIDTH  fetched instruction word
iv_valid  out  1  fetch complete (1-cycle pulse)
da_in  in  32  data-read byte address
da_in_enable  in  1  data-read request (level)
dv_in  out  DATA_WIDTH  read data word
dv_in_valid  out  1  read complete (1-cycle pulse)
da_out  in  32  data-write byte address
da_out_enable  in  1  data-write request (level)
dv_out  in  DATA_WIDTH  write data word
dv_out_valid  out  1  write complete (1-cycle pulse)
mem_address  out  ADDR_WIDTH  word-aligned address: {addr[ADDR_WIDTH-1:2], 2'b00}
mem_read_n  out  1  read strobe, active-low
mem_write_n  out  1  write strobe, active-low
mem_write_data  out  DATA_WIDTH  write data
mem_read_data  in  DATA_WIDTH  read data from memory
mem_ready_n  in  1  memory read-data-ready / write-done, active-low
busy  out  1  high whenever the arbiter is not in IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - mem_read_n = 1, mem_write_n = 1.
  - mem_address, mem_write_data, iv, dv_in = 0.
  - All *_valid = 0, busy = 0.
  - state = IDLE, grant = NONE.
- States:
  - IDLE:
    - If any enable is high, pick a winner per the priority rule.
    - Latch the winner's aligned address (and dv_out for a write).
    - Assert the matching strobe low at the next edge and go to WAIT.
  - WAIT:
    - Hold the strobe, address and data stable.
    - On a cycle with mem_ready_n == 0: deassert the strobe at the next edge, capture mem_read_data into iv or dv_in (read grants only), pulse the granted *_valid for exactly one cycle, and go to DONE.
  - DONE:
    - One dead cycle with both strobes high.
    - Return to IDLE. Arbitration is re-evaluated in IDLE.
- Fixed priority (default): write > data read > instruction.
- Latency: request seen at edge N gives strobe low from edge N+1. mem_ready_n seen low at edge M gives valid high for the cycle after edge M+1 only. Minimum request-to-valid is 2 cycles. The next grant has a strobe no earlier than 2 cycles after valid.
- Requester contract:
  - Hold enable and address stable until valid is seen.
  - Enable still high in the cycle after valid counts as a new request.
  - Dropping enable before valid does not abort the transaction. Valid still pulses and the core ignores it.
- Only the granted requester's valid may pulse. Never pulse two valids in one cycle.
- iv and dv_in hold their last captured value until the next capture for the same requester.
- Addresses above ADDR_WIDTH are truncated. Bits [1:0] are forced to 0.
- mem_ready_n low in IDLE or DONE is ignored; no valid pulses.
- Simultaneous requests: exactly one is granted. The others stay pending, with no loss and no duplication.
- Reset mid-transaction:
  - Strobes go high at the next edge and state returns to IDLE.
  - No valid pulses.
  - A late mem_ready_n after reset is ignored.
- Both strobes are never low at the same time.

Optional Feature:
MEM_PORT_ARBITER_RR_EN
- Defined: round-robin arbitration.
  - Priority order starts at write > read > instruction after reset.
  - After each grant, the granted requester becomes lowest priority.
  - A requester with its enable held continuously is guaranteed service within 3 grants.
- Undefined: fixed priority as above. The instruction requester may starve under continuous write/read traffic.

Test Plan:
- Reset: hold reset 2 cycles with all enables high -> all strobes 1, all valids 0, busy 0. First strobe appears no earlier than 1 cycle after reset falls.
- Single fetch: ia=0x00000107, ia_enable=1; memory returns 0xDEADBEEF with mem_ready_n low for 1 cycle, 3 cycles after the strobe -> mem_address=0x0000104, mem_read_n low 4 cycles, iv=0xDEADBEEF, iv_valid high exactly 1 cycle.
- Contention (fixed priority): all three enables raised in the same cycle, memory ready after 1 cycle -> grant order write(da_out=0x20, dv_out=0x55AA55AA), then read(0x40), then fetch(0x80). mem_write_data=0x55AA55AA; dv_out_valid, dv_in_valid, iv_valid pulse in that order.
- Starvation check: with MEM_PORT_ARBITER_RR_EN, hold all enables high for 12 grants -> each requester granted exactly 4 times in rotation. Without the macro, iv_valid never pulses.
- Spurious ready and reset mid-op: mem_ready_n low while IDLE -> no valid. Start a read at 0x100, assert reset in WAIT, then return mem_ready_n low -> mem_read_n=1 after the reset edge, no dv_in_valid, state IDLE.
- Strobe exclusivity: random enables and random memory latency (1-8 cycles) for 10k cycles -> mem_read_n and mem_write_n never both 0. Each enable episode is answered by exactly one valid pulse.
